// File: rtl/matrix_loader_if.sv
// Byte-stream load interface between the HPS-side bus and the matrix loader.
// Carries control, element handshake and the two packed matrix vectors.
interface matrix_loader_if #(
    parameter int ELEM_W = 8,
    parameter int MAT_W  = 200
);
    logic              start;
    logic [1:0]        size;
    logic              in_valid;
    logic [ELEM_W-1:0] in_data;
    logic              in_ready;
    logic [MAT_W-1:0]  matrix1_out;
    logic [MAT_W-1:0]  matrix2_out;
    logic              busy;
    logic              done;

    modport master (
        output start, size, in_valid, in_data,
        input  in_ready, matrix1_out, matrix2_out, busy, done
    );

    modport slave (
        input  start, size, in_valid, in_data,
        output in_ready, matrix1_out, matrix2_out, busy, done
    );
endinterface

// File: rtl/matrix_loader.sv
// Packs n*n streamed bytes MSB-first into matrix A, then n*n into matrix B,
// and pulses done once both are complete.
//
// state   | meaning
// IDLE    | waiting for start; outputs hold the last result
// LOAD_A  | accepting elements of matrix A
// LOAD_B  | accepting elements of matrix B
// DONE    | one-cycle done pulse, then back to IDLE
module matrix_loader #(
    parameter int ELEM_W  = 8,
    parameter int MAX_DIM = 5,
    parameter int MAT_W   = MAX_DIM * MAX_DIM * ELEM_W
) (
    input  logic            clk,
    input  logic            reset,
    matrix_loader_if.slave  bus
);
    localparam int SLOTS = MAX_DIM * MAX_DIM;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD_A = 2'd1;
    localparam logic [1:0] ST_LOAD_B = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    logic [1:0]       state;
    logic [4:0]       cnt;
    logic [1:0]       size_q;
    logic [4:0]       cnt_last;
    logic [MAT_W-1:0] m1_q;
    logic [MAT_W-1:0] m2_q;
    logic             loading;
    logic             xfer;

    // Slot k occupies the k-th byte from the top; unwritten slots stay zero.
    function automatic logic [MAT_W-1:0] put_slot(
        input logic [MAT_W-1:0]  v,
        input logic [4:0]        idx,
        input logic [ELEM_W-1:0] d
    );
        logic [MAT_W-1:0] r;
        r = v;
        for (int k = 0; k < SLOTS; k++) begin
            if (idx == 5'(k)) begin
                r[MAT_W-1-k*ELEM_W -: ELEM_W] = d;
            end
        end
        return r;
    endfunction

    always_comb begin
        cnt_last = 5'd24;
        case (size_q)
            2'd0:    cnt_last = 5'd3;
            2'd1:    cnt_last = 5'd8;
            2'd2:    cnt_last = 5'd15;
            default: cnt_last = 5'd24;
        endcase
    end

    assign loading = (state == ST_LOAD_A) || (state == ST_LOAD_B);
    assign xfer    = loading && bus.in_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            cnt    <= 5'd0;
            size_q <= 2'd0;
            m1_q   <= '0;
            m2_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        size_q <= bus.size;
                        m1_q   <= '0;
                        m2_q   <= '0;
                        cnt    <= 5'd0;
                        state  <= ST_LOAD_A;
                    end
                end
                ST_LOAD_A: begin
                    if (xfer) begin
                        m1_q <= put_slot(m1_q, cnt, bus.in_data);
                        if (cnt == cnt_last) begin
                            cnt   <= 5'd0;
                            state <= ST_LOAD_B;
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                end
                ST_LOAD_B: begin
                    if (xfer) begin
                        m2_q <= put_slot(m2_q, cnt, bus.in_data);
                        if (cnt == cnt_last) begin
                            cnt   <= 5'd0;
                            state <= ST_DONE;
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready    = loading;
    assign bus.busy        = loading;
    assign bus.done        = (state == ST_DONE);
    assign bus.matrix1_out = m1_q;
    assign bus.matrix2_out = m2_q;
endmodule

// File: tb/tb_matrix_loader.sv
// Scoreboard bench for matrix_loader: each load pushes its expected packed
// vectors and latency; the done monitor pops and compares them.
module tb_matrix_loader;
    logic clk = 1'b0;
    logic reset;

    matrix_loader_if bus ();

    matrix_loader dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [199:0] m1;
        logic [199:0] m2;
        int           lat;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           start_cyc = 0;
    int           ndone = 0;
    logic [199:0] last_m1 = '0;
    logic [199:0] last_m2 = '0;

    task automatic check(input string tag, input logic [199:0] got, input logic [199:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin : done_mon
        exp_t e;
        if (bus.done === 1'b1) begin
            ndone++;
            if (sb.size() == 0) begin
                check("sb_underflow", 200'd0, 200'd1);
            end else begin
                e = sb.pop_front();
                check("m1", bus.matrix1_out, e.m1);
                check("m2", bus.matrix2_out, e.m2);
                if (e.lat > 0) check("done_lat", 200'(cyc - start_cyc + 2), 200'(e.lat));
                last_m1 = e.m1;
                last_m2 = e.m2;
            end
        end
    end

    task automatic do_start(input logic [1:0] sz);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.size  = sz;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        bus.start = 1'b0;
    endtask

    task automatic send_beat(input logic [7:0] d, input int gap);
        bus.in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        check("beat_timeout", 200'd0, 200'd1);
    endtask

    task automatic run_load(input logic [1:0] sz, input int gapmax, input bit b_ff, input bit pulse);
        exp_t       e;
        logic [7:0] a_v [25];
        logic [7:0] b_v [25];
        int         n;
        int         d0;
        n  = (int'(sz) + 2) * (int'(sz) + 2);
        e.m1 = '0;
        e.m2 = '0;
        for (int k = 0; k < n; k++) begin
            a_v[k] = 8'(k + 1);
            b_v[k] = b_ff ? 8'hFF : 8'(n + k + 1);
            e.m1[199 - 8*k -: 8] = a_v[k];
            e.m2[199 - 8*k -: 8] = b_v[k];
        end
        e.lat = (gapmax == 0) ? 2*n + 2 : 0;
        sb.push_back(e);
        d0 = ndone;
        do_start(sz);
        check("busy_load", 200'(bus.busy), 200'd1);
        check("clear_m1", bus.matrix1_out, 200'd0);
        check("clear_m2", bus.matrix2_out, 200'd0);
        for (int k = 0; k < 2*n; k++) begin
            if (pulse && k == n + 1) begin
                bus.start = 1'b1;
                bus.size  = 2'd3 - sz;
            end
            send_beat(k < n ? a_v[k] : b_v[k - n], gapmax > 0 ? int'($urandom_range(0, gapmax)) : 0);
            bus.start = 1'b0;
        end
        bus.in_valid = 1'b0;
        for (int t = 0; t < 20 && ndone == d0; t++) @(posedge clk);
        #1;
        check("done_count", 200'(ndone - d0), 200'd1);
        check("busy_after", 200'(bus.busy), 200'd0);
        check("done_after", 200'(bus.done), 200'd0);
    endtask

    initial begin
        int d0;
        bus.start    = 1'b0;
        bus.size     = 2'd0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        reset        = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.size  = 2'd3;
        repeat (2) @(posedge clk);
        #1;
        reset     = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check("rst_m1", bus.matrix1_out, 200'd0);
        check("rst_m2", bus.matrix2_out, 200'd0);
        check("rst_ready", 200'(bus.in_ready), 200'd0);
        check("rst_busy", 200'(bus.busy), 200'd0);
        check("rst_done", 200'(bus.done), 200'd0);

        run_load(2'd0, 0, 1'b0, 1'b0);
        check("m1_2x2_top", 200'(bus.matrix1_out[199:168]), 200'h01020304);
        check("m2_2x2_top", 200'(bus.matrix2_out[199:168]), 200'h05060708);
        check("m1_2x2_low", 200'(bus.matrix1_out[167:0]), 200'd0);
        check("m2_2x2_low", 200'(bus.matrix2_out[167:0]), 200'd0);

        run_load(2'd3, 0, 1'b1, 1'b0);
        check("m2_5x5_ones", bus.matrix2_out, {200{1'b1}});
        check("m1_5x5_last", 200'(bus.matrix1_out[7:0]), 200'h19);

        run_load(2'd1, 3, 1'b0, 1'b0);
        check("m1_3x3_low", 200'(bus.matrix1_out[127:0]), 200'd0);
        check("m1_3x3_top", 200'(bus.matrix1_out[199:192]), 200'h01);

        // Mid-load reset: no scoreboard entry, so any done would underflow.
        d0 = ndone;
        do_start(2'd2);
        for (int k = 0; k < 7; k++) send_beat(8'(k + 1), 0);
        bus.in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_m1", bus.matrix1_out, 200'd0);
        check("abort_m2", bus.matrix2_out, 200'd0);
        check("abort_busy", 200'(bus.busy), 200'd0);
        check("abort_ready", 200'(bus.in_ready), 200'd0);
        repeat (40) @(posedge clk);
        #1;
        check("abort_no_done", 200'(ndone - d0), 200'd0);

        run_load(2'd0, 0, 1'b0, 1'b1);

        bus.in_valid = 1'b1;
        bus.in_data  = 8'hAA;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            check("idle_ready", 200'(bus.in_ready), 200'd0);
        end
        bus.in_valid = 1'b0;
        check("retain_m1", bus.matrix1_out, last_m1);
        check("retain_m2", bus.matrix2_out, last_m2);

        run_load(2'd3, 0, 1'b0, 1'b0);
        run_load(2'd0, 0, 1'b0, 1'b0);
        check("sb_empty", 200'(sb.size()), 200'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
